alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
- REQ-001: Parameters: DATA_W, 16, operand width. REG_W, 3, register index width.
- REQ-002: clk  in  1  rising-edge clock.
- REQ-003: rst_n  in  1  asynchronous, active-low reset.
- REQ-004: in_valid / in_ready  in / out  1 / 1  upstream (decode) handshake; transfer when both are high.
- REQ-005: in_rd1, in_rd2  in  DATA_W  register-file read data; in_rs1, in_rs2  in  REG_W  source indices.
- REQ-006: in_op  in  2  ALU op (00 add, 01 sub, 10 xor, 11 and-not); in_sign, in_cin  in  1 each; in_wr_idx  in  REG_W; in_wr_en  in  1.
- REQ-007: exm_wr_en, exm_wr_idx, exm_data  in  1/REG_W/DATA_W  EX/MEM result bypass.
- REQ-008: wb_wr_en, wb_wr_idx, wb_data  in  1/REG_W/DATA_W  write-back bypass.
- REQ-009: flush  in  1  squash held and incoming instruction.
- REQ-010: out_valid / out_ready  out / in  1 / 1  downstream (arith) handshake.
- REQ-011: out_A, out_B  out  DATA_W; out_op  out  2; out_sign, out_cin, out_wr_en  out  1; out_wr_idx  out  REG_W: registered operands and controls for the arith unit.

Function
- REQ-012: One register stage; latency is 1 cycle from accepted input to out_valid.
- REQ-013: in_ready SHALL equal (~out_valid | out_ready), combinationally; no combinational path from in_valid to out_valid.
- REQ-014: States: EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on accept. FULL->EMPTY on out_ready with no accept. FULL->FULL on a simultaneous drain and accept, or on a hold.
- REQ-015: Operand selection at capture, per source: EX/MEM match (exm_wr_en and exm_wr_idx == rsN) first, else WB match, else in_rdN.
- REQ-016: While FULL and not draining (out_ready=0), a held operand whose source index matches an active WB write SHALL be overwritten with wb_data. EX/MEM does not refresh held operands.
- REQ-017: Held source indices SHALL be stored internally to support REQ-016.
- REQ-018: flush SHALL clear out_valid next cycle and block capture that cycle. flush wins over a simultaneous accept. in_ready is unaffected by flush.
- REQ-019: out_wr_en SHALL be forced 0 whenever out_valid is 0.
- REQ-020: All outputs SHALL be registered. Data fields change only on capture or refresh.

Reset
- REQ-021: On rst_n low, asynchronously: out_valid=0, out_A=out_B=0, out_op=00, out_sign=out_cin=out_wr_en=0, out_wr_idx=0, held indices 0.
- REQ-022: Reset mid-transfer SHALL drop the held instruction. The first accept after rst_n rises behaves as from EMPTY.

Configuration
- REQ-023: Macro ALU_OPERAND_FWD_EN. When defined, REQ-015/REQ-016 bypass logic is built.
- REQ-024: When undefined, operands come only from in_rd1/in_rd2 and no refresh occurs. Bypass inputs stay as ports but are ignored. Handshake behaviour is identical.

Structure
- REQ-025: A shared package SHALL hold DATA_W/REG_W constants, the op-code enum (ADD, SUB, XOR, ANDN), and the stage payload struct type.
- REQ-026: One sub-module, operand_bypass_mux, SHALL implement per-operand priority selection. It is instantiated twice and is combinational.

Verification
- REQ-027: Accept rd1=0x1234, rd2=0x0001, op=00, out_ready=1 -> next cycle out_valid=1, A=0x1234, B=0x0001, op=00.
- REQ-028: rs1=3; exm_wr_idx=3, exm_data=0xBEEF; wb_wr_idx=3, wb_data=0x1111 -> A=0xBEEF. With the macro undefined -> A=in_rd1.
- REQ-029: FULL with out_ready=0 for 3 cycles; wb write to held rs2 with 0x00AA in cycle 2 -> B=0x00AA from cycle 3. in_ready=0 throughout.
- REQ-030: FULL; out_ready=1 and in_valid=1 same cycle -> new payload next cycle, out_valid stays 1, no bubble.
- REQ-031: flush together with in_valid=1 -> out_valid=0 and out_wr_en=0 next cycle.
- REQ-032: rst_n low while FULL -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// Shared constants and types for the ALU operand stage and its bypass muxes.
package alu_operand_stage_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;

    typedef enum logic [1:0] {
        OpAdd  = 2'b00,
        OpSub  = 2'b01,
        OpXor  = 2'b10,
        OpAndn = 2'b11
    } alu_op_e;

    // Control half of the stage payload; operands and indices are sized by the top's parameters.
    typedef struct packed {
        alu_op_e op;
        logic    sign;
        logic    cin;
        logic    wr_en;
    } stage_ctrl_t;

endpackage

// File: rtl/alu_operand_stage_bypass_mux.sv
// Per-operand source priority: EX/MEM result, then write-back result, then register file.
module operand_bypass_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W = alu_operand_stage_pkg::DATA_W,
    parameter int unsigned REG_W  = alu_operand_stage_pkg::REG_W
) (
    input  logic [REG_W-1:0]  rs,
    input  logic [DATA_W-1:0] rd,
    input  logic              exm_wr_en,
    input  logic [REG_W-1:0]  exm_wr_idx,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_wr_en,
    input  logic [REG_W-1:0]  wb_wr_idx,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = rd;
        if (exm_wr_en && (exm_wr_idx == rs)) begin
            data = exm_data;
        end else if (wb_wr_en && (wb_wr_idx == rs)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// One-deep operand register stage between decode and the arith unit.
// Define ALU_OPERAND_FWD_EN to build EX/MEM and WB bypassing plus held-operand refresh.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W = alu_operand_stage_pkg::DATA_W,
    parameter int unsigned REG_W  = alu_operand_stage_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rd1,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [1:0]        in_op,
    input  logic              in_sign,
    input  logic              in_cin,
    input  logic [REG_W-1:0]  in_wr_idx,
    input  logic              in_wr_en,
    input  logic              exm_wr_en,
    input  logic [REG_W-1:0]  exm_wr_idx,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_wr_en,
    input  logic [REG_W-1:0]  wb_wr_idx,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_A,
    output logic [DATA_W-1:0] out_B,
    output logic [1:0]        out_op,
    output logic              out_sign,
    output logic              out_cin,
    output logic              out_wr_en,
    output logic [REG_W-1:0]  out_wr_idx
);

`ifdef ALU_OPERAND_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    stage_ctrl_t       ctrl_q;
    stage_ctrl_t       in_ctrl;
    logic [REG_W-1:0]  rs1_q, rs2_q;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic              exm_en, wb_en;
    logic              accept, refresh_a, refresh_b;

    // Without forwarding the muxes see no active writer and pass the register file through.
    assign exm_en = FwdEn & exm_wr_en;
    assign wb_en  = FwdEn & wb_wr_en;

    operand_bypass_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mux_a (
        .rs         (in_rs1),
        .rd         (in_rd1),
        .exm_wr_en  (exm_en),
        .exm_wr_idx (exm_wr_idx),
        .exm_data   (exm_data),
        .wb_wr_en   (wb_en),
        .wb_wr_idx  (wb_wr_idx),
        .wb_data    (wb_data),
        .data       (sel_a)
    );

    operand_bypass_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mux_b (
        .rs         (in_rs2),
        .rd         (in_rd2),
        .exm_wr_en  (exm_en),
        .exm_wr_idx (exm_wr_idx),
        .exm_data   (exm_data),
        .wb_wr_en   (wb_en),
        .wb_wr_idx  (wb_wr_idx),
        .wb_data    (wb_data),
        .data       (sel_b)
    );

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    assign in_ctrl = '{op: alu_op_e'(in_op), sign: in_sign, cin: in_cin, wr_en: in_wr_en};

    // A stalled instruction keeps picking up write-back results aimed at its sources.
    assign refresh_a = out_valid & ~out_ready & wb_en & (wb_wr_idx == rs1_q);
    assign refresh_b = out_valid & ~out_ready & wb_en & (wb_wr_idx == rs2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_A      <= '0;
            out_B      <= '0;
            ctrl_q     <= '0;
            out_wr_idx <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            ctrl_q.wr_en <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_A      <= sel_a;
            out_B      <= sel_b;
            ctrl_q     <= in_ctrl;
            out_wr_idx <= in_wr_idx;
            rs1_q      <= in_rs1;
            rs2_q      <= in_rs2;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
            ctrl_q.wr_en <= 1'b0;
        end else begin
            if (refresh_a) out_A <= wb_data;
            if (refresh_b) out_B <= wb_data;
        end
    end

    assign out_op    = ctrl_q.op;
    assign out_sign  = ctrl_q.sign;
    assign out_cin   = ctrl_q.cin;
    assign out_wr_en = ctrl_q.wr_en;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed table, corner sequences, random vs model.
module tb_alu_operand_stage;

    localparam int DW = 16;
    localparam int RW = 3;
`ifdef ALU_OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_rd1, in_rd2;
    logic [RW-1:0] in_rs1, in_rs2, in_wr_idx;
    logic [1:0]    in_op;
    logic          in_sign, in_cin, in_wr_en;
    logic          exm_wr_en, wb_wr_en;
    logic [RW-1:0] exm_wr_idx, wb_wr_idx;
    logic [DW-1:0] exm_data, wb_data;
    logic          flush;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_A, out_B;
    logic [1:0]    out_op;
    logic          out_sign, out_cin, out_wr_en;
    logic [RW-1:0] out_wr_idx;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd1     (in_rd1),
        .in_rd2     (in_rd2),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_op      (in_op),
        .in_sign    (in_sign),
        .in_cin     (in_cin),
        .in_wr_idx  (in_wr_idx),
        .in_wr_en   (in_wr_en),
        .exm_wr_en  (exm_wr_en),
        .exm_wr_idx (exm_wr_idx),
        .exm_data   (exm_data),
        .wb_wr_en   (wb_wr_en),
        .wb_wr_idx  (wb_wr_idx),
        .wb_data    (wb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_A      (out_A),
        .out_B      (out_B),
        .out_op     (out_op),
        .out_sign   (out_sign),
        .out_cin    (out_cin),
        .out_wr_en  (out_wr_en),
        .out_wr_idx (out_wr_idx)
    );

    typedef struct {
        logic [DW-1:0] a, b;
        logic [1:0]    op;
        logic          sign, cin, wr_en;
        logic [RW-1:0] wr_idx, rs1, rs2;
    } item_t;

    typedef struct {
        string         name;
        logic [DW-1:0] rd1, rd2;
        logic [RW-1:0] rs1, rs2;
        logic [1:0]    op;
        logic          exm_en;
        logic [RW-1:0] exm_idx;
        logic [DW-1:0] exm_dat;
        logic          wb_en;
        logic [RW-1:0] wb_idx;
        logic [DW-1:0] wb_dat;
        logic [DW-1:0] exp_a, exp_b;
    } vec_t;

    item_t held[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pick(input logic [RW-1:0] rs, input logic [DW-1:0] rd);
        if (FWD && exm_wr_en && exm_wr_idx == rs) return exm_data;
        if (FWD && wb_wr_en && wb_wr_idx == rs) return wb_data;
        return rd;
    endfunction

    // Model: the stage holds at most one instruction; apply one clock edge.
    task automatic model_edge();
        item_t it;
        bit    rdy;
        rdy = (held.size() == 0) || out_ready;
        if (flush) begin
            held.delete();
        end else if (in_valid && rdy) begin
            it.a = pick(in_rs1, in_rd1);
            it.b = pick(in_rs2, in_rd2);
            it.op = in_op; it.sign = in_sign; it.cin = in_cin; it.wr_en = in_wr_en;
            it.wr_idx = in_wr_idx; it.rs1 = in_rs1; it.rs2 = in_rs2;
            held.delete();
            held.push_back(it);
        end else if (held.size() != 0 && out_ready) begin
            held.delete();
        end else if (held.size() != 0 && FWD && wb_wr_en) begin
            if (wb_wr_idx == held[0].rs1) held[0].a = wb_data;
            if (wb_wr_idx == held[0].rs2) held[0].b = wb_data;
        end
    endtask

    task automatic compare_outputs();
        check("out_valid", 32'(out_valid), 32'(held.size() != 0));
        if (held.size() != 0) begin
            check("out_A", 32'(out_A), 32'(held[0].a));
            check("out_B", 32'(out_B), 32'(held[0].b));
            check("out_op", 32'(out_op), 32'(held[0].op));
            check("out_sign", 32'(out_sign), 32'(held[0].sign));
            check("out_cin", 32'(out_cin), 32'(held[0].cin));
            check("out_wr_en", 32'(out_wr_en), 32'(held[0].wr_en));
            check("out_wr_idx", 32'(out_wr_idx), 32'(held[0].wr_idx));
        end else begin
            check("out_wr_en_idle", 32'(out_wr_en), 32'd0);
        end
    endtask

    // Inputs are driven just after a negedge; this runs one full clock.
    task automatic cycle();
        #1;
        check("in_ready", 32'(in_ready), 32'((held.size() == 0) || out_ready));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic set_idle();
        in_valid = 0; in_rd1 = '0; in_rd2 = '0; in_rs1 = '0; in_rs2 = '0; in_op = 2'b00;
        in_sign = 0; in_cin = 0; in_wr_idx = '0; in_wr_en = 0;
        exm_wr_en = 0; exm_wr_idx = '0; exm_data = '0;
        wb_wr_en = 0; wb_wr_idx = '0; wb_data = '0;
        flush = 0; out_ready = 1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_A"}, 32'(out_A), 32'd0);
        check({tag, "_B"}, 32'(out_B), 32'd0);
        check({tag, "_ctrl"}, 32'({out_op, out_sign, out_cin, out_wr_en, out_wr_idx}), 32'd0);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        held.delete();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic load(input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                        input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                        input logic [1:0] op, input logic wr_en);
        in_valid = 1; in_rd1 = rd1; in_rd2 = rd2; in_rs1 = rs1; in_rs2 = rs2;
        in_op = op; in_wr_en = wr_en; in_wr_idx = 3'd6; in_sign = 1; in_cin = 0;
    endtask

    vec_t vecs[5];

    initial begin
        rst_n = 1;
        set_idle();
        vecs[0] = '{"basic_add", 16'h1234, 16'h0001, 3'd1, 3'd2, 2'b00, 0, 3'd0, 16'h0,
                    0, 3'd0, 16'h0, 16'h1234, 16'h0001};
        vecs[1] = '{"exm_over_wb", 16'h2222, 16'h3333, 3'd3, 3'd4, 2'b01, 1, 3'd3, 16'hBEEF,
                    1, 3'd3, 16'h1111, FWD ? 16'hBEEF : 16'h2222, 16'h3333};
        vecs[2] = '{"wb_only_b", 16'h0F0F, 16'h7777, 3'd0, 3'd5, 2'b10, 1, 3'd2, 16'hDEAD,
                    1, 3'd5, 16'h5A5A, 16'h0F0F, FWD ? 16'h5A5A : 16'h7777};
        vecs[3] = '{"exm_both", 16'hAAAA, 16'h5555, 3'd7, 3'd7, 2'b11, 1, 3'd7, 16'hC0DE,
                    0, 3'd7, 16'h9999, FWD ? 16'hC0DE : 16'hAAAA, FWD ? 16'hC0DE : 16'h5555};
        vecs[4] = '{"wr_disabled", 16'h4444, 16'h6666, 3'd1, 3'd1, 2'b00, 0, 3'd1, 16'hFFFF,
                    0, 3'd1, 16'hEEEE, 16'h4444, 16'h6666};

        @(negedge clk);
        do_reset();

        // Directed table: one accept each, then drain.
        foreach (vecs[i]) begin
            load(vecs[i].rd1, vecs[i].rd2, vecs[i].rs1, vecs[i].rs2, vecs[i].op, 1'b1);
            exm_wr_en = vecs[i].exm_en; exm_wr_idx = vecs[i].exm_idx; exm_data = vecs[i].exm_dat;
            wb_wr_en = vecs[i].wb_en; wb_wr_idx = vecs[i].wb_idx; wb_data = vecs[i].wb_dat;
            out_ready = 1;
            cycle();
            check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            check({vecs[i].name, "_A"}, 32'(out_A), 32'(vecs[i].exp_a));
            check({vecs[i].name, "_B"}, 32'(out_B), 32'(vecs[i].exp_b));
            check({vecs[i].name, "_op"}, 32'(out_op), 32'(vecs[i].op));
            set_idle();
            cycle();
            check({vecs[i].name, "_drained"}, 32'(out_valid), 32'd0);
        end

        // Stall three cycles; WB hits held rs2 in the second.
        load(16'h0100, 16'h0042, 3'd2, 3'd5, 2'b01, 1'b1);
        out_ready = 0;
        cycle();
        set_idle(); out_ready = 0;
        check("stall_ready_c1", 32'(in_ready), 32'd0);
        cycle();
        wb_wr_en = 1; wb_wr_idx = 3'd5; wb_data = 16'h00AA;
        check("stall_ready_c2", 32'(in_ready), 32'd0);
        cycle();
        wb_wr_en = 0;
        check("stall_ready_c3", 32'(in_ready), 32'd0);
        check("stall_refresh_B", 32'(out_B), FWD ? 32'h00AA : 32'h0042);
        check("stall_keep_A", 32'(out_A), 32'h0100);
        cycle();
        check("stall_refresh_B_kept", 32'(out_B), FWD ? 32'h00AA : 32'h0042);

        // Drain and accept together: no bubble.
        load(16'hCAFE, 16'hF00D, 3'd1, 3'd2, 2'b10, 1'b1);
        out_ready = 1;
        cycle();
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_A", 32'(out_A), 32'hCAFE);

        // Flush wins over a simultaneous accept.
        load(16'h1357, 16'h2468, 3'd3, 3'd4, 2'b00, 1'b1);
        flush = 1;
        cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_wr_en", 32'(out_wr_en), 32'd0);
        set_idle();

        // Asynchronous reset while FULL, sampled before any clock edge.
        load(16'h8888, 16'h9999, 3'd1, 3'd2, 2'b11, 1'b1);
        out_ready = 0;
        cycle();
        check("pre_reset_full", 32'(out_valid), 32'd1);
        set_idle();
        #2;
        rst_n = 0;
        held.delete();
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1;
        load(16'h0BAD, 16'h0C0D, 3'd0, 3'd0, 2'b01, 1'b1);
        cycle();
        check("post_reset_A", 32'(out_A), 32'h0BAD);
        set_idle();
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            in_rd1     = DW'($urandom); in_rd2 = DW'($urandom);
            in_rs1     = RW'($urandom); in_rs2 = RW'($urandom);
            in_op      = 2'($urandom); in_sign = 1'($urandom); in_cin = 1'($urandom);
            in_wr_en   = 1'($urandom); in_wr_idx = RW'($urandom);
            exm_wr_en  = 1'($urandom); exm_wr_idx = RW'($urandom); exm_data = DW'($urandom);
            wb_wr_en   = 1'($urandom); wb_wr_idx = RW'($urandom); wb_data = DW'($urandom);
            flush      = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
